// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte per frame and shifts it out as 8N1/8N2 UART.
// The FIFO sees s_ready only in IDLE, so it stalls for the whole frame.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       tx,
    output logic       busy
);

    localparam int BW = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam logic [BW-1:0] BIT_END = BW'(CLKS_PER_BIT - 1);
    // One cycle short: the IDLE accept cycle completes the last stop bit.
    localparam logic [BW-1:0] STOP_END = BW'(STOP_BITS * CLKS_PER_BIT - 2);

    if (CLKS_PER_BIT < 2 || !(STOP_BITS == 1 || STOP_BITS == 2)) begin : g_bad_param
        $error("fifo_uart_tx: illegal CLKS_PER_BIT or STOP_BITS");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_nx;
    logic [BW-1:0] baud, baud_nx;
    logic [2:0]    bit_cnt, bit_nx;
    logic [7:0]    shift, shift_nx;
    logic          tx_nx;

    assign s_ready = (state == IDLE) && !rst;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nx;
            baud    <= baud_nx;
            bit_cnt <= bit_nx;
            shift   <= shift_nx;
            tx      <= tx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        baud_nx  = baud + 1'b1;
        bit_nx   = bit_cnt;
        shift_nx = shift;
        tx_nx    = tx;
        unique case (state)
            IDLE: begin
                baud_nx = '0;
                tx_nx   = 1'b1;
                if (s_valid && s_ready) begin
                    state_nx = START;
                    shift_nx = s_data;
                    bit_nx   = '0;
                    tx_nx    = 1'b0;
                end
            end
            START: begin
                if (baud == BIT_END) begin
                    state_nx = DATA;
                    baud_nx  = '0;
                    bit_nx   = '0;
                    tx_nx    = shift[0];
                    shift_nx = {1'b0, shift[7:1]};
                end
            end
            DATA: begin
                if (baud == BIT_END) begin
                    baud_nx = '0;
                    if (bit_cnt == 3'd7) begin
                        state_nx = STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        bit_nx   = bit_cnt + 3'd1;
                        tx_nx    = shift[0];
                        shift_nx = {1'b0, shift[7:1]};
                    end
                end
            end
            STOP: begin
                tx_nx = 1'b1;
                if (baud == STOP_END) begin
                    state_nx = IDLE;
                    baud_nx  = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                baud_nx  = '0;
                tx_nx    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: scoreboard of expected bytes, line monitor decodes frames.
// Second instance (CPB=2, two stop bits) checks frame period and stop time.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready, tx, busy;

    logic       b_rst = 1'b1;
    logic       b_valid = 1'b0;
    logic [7:0] b_data = 8'h00;
    logic       b_ready, b_tx, b_busy;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .tx(tx), .busy(busy)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(b_rst), .s_valid(b_valid), .s_data(b_data),
        .s_ready(b_ready), .tx(b_tx), .busy(b_busy)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] sb[$];
    int n_abort = 0;
    int n_frames = 0;
    logic mon_busy = 1'b0;
    logic rst_seen = 1'b0;

    int cyc = 0;
    int acc_a = 0, a_last = 0, a_prev = 0;
    int acc_b = 0, b_last = 0, b_prev = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (s_valid && s_ready) begin
            acc_a  <= acc_a + 1;
            a_prev <= a_last;
            a_last <= cyc;
        end
        if (b_valid && b_ready) begin
            acc_b  <= acc_b + 1;
            b_prev <= b_last;
            b_last <= cyc;
        end
    end

    always @(posedge rst) rst_seen = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Line monitor: finds each start bit and samples every bit at its centre.
    initial begin : monitor
        logic       prev;
        logic [7:0] want;
        logic [9:0] got, exp_line;
        prev = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && prev && !tx) begin
                mon_busy = 1'b1;
                rst_seen = 1'b0;
                want = 8'h00;
                if (sb.size() == 0)
                    chk("unexpected_frame", 1, 0);
                else
                    want = sb.pop_front();
                repeat (CPB / 2) @(posedge clk);
                #1 got[0] = tx;
                for (int i = 1; i < 10; i++) begin
                    repeat (CPB) @(posedge clk);
                    #1 got[i] = tx;
                end
                exp_line = {1'b1, want, 1'b0};
                if (rst_seen) begin
                    n_abort++;
                end else begin
                    for (int i = 0; i < 10; i++)
                        chk($sformatf("frame%0d_bit%0d", n_frames, i),
                            int'(got[i]), int'(exp_line[i]));
                    n_frames++;
                end
                mon_busy = 1'b0;
            end
            prev = tx;
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk({name, "_ready_timeout"}, 0, 1);
    endtask

    task automatic wait_mon_idle(input string name);
        int n;
        n = 0;
        while ((mon_busy || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (mon_busy || sb.size() != 0) chk({name, "_mon_timeout"}, 0, 1);
    endtask

    task automatic send(input logic [7:0] b);
        wait_ready("send");
        s_valid = 1'b1;
        s_data  = b;
        sb.push_back(b);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, nb, ones;

        // Reset values, release, and an asynchronous reset while idle
        @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(s_ready), 0);
        rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);
        chk("release_ready", int'(s_ready), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ready", int'(s_ready), 0);
        chk("async_rst_tx", int'(tx), 1);
        chk("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rerelease_ready", int'(s_ready), 1);
        repeat (5) @(negedge clk);
        chk("idle_tx_high", int'(tx), 1);
        chk("idle_no_pop", acc_a, 0);

        // Single byte; busy covers the frame minus its accept cycle
        send(8'hA5);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, (9 + 1) * CPB - 1);
        wait_mon_idle("a5");

        // Back-to-back with s_valid held high
        wait_ready("b2b");
        nb = acc_a;
        s_valid = 1'b1;
        s_data  = 8'h00;
        sb.push_back(8'h00);
        sb.push_back(8'hFF);
        @(posedge clk);
        @(negedge clk);
        s_data = 8'hFF;
        n = 0;
        while (acc_a < nb + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        s_valid = 1'b0;
        chk("b2b_accepts", acc_a - nb, 2);
        chk("b2b_spacing", a_last - a_prev, (9 + 1) * CPB);
        wait_mon_idle("b2b");

        // Input disturbance during DATA must not reach the line
        nb = acc_a;
        send(8'h5A);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            s_valid = ~s_valid;
            s_data  = 8'h3C;
            @(negedge clk);
        end
        s_valid = 1'b0;
        wait_mon_idle("dist");
        chk("dist_single_pop", acc_a - nb, 1);

        // Reset 15 cycles into a frame abandons it
        send(8'h77);
        repeat (14) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx", int'(tx), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(s_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_release_ready", int'(s_ready), 1);
        wait_mon_idle("midrst");
        send(8'h81);
        wait_mon_idle("x81");

        chk("frames_checked", n_frames, 5);
        chk("frames_aborted", n_abort, 1);
        chk("total_pops", acc_a, 6);

        // Two stop bits, CPB=2: 22-cycle period, 4 cycles of line high
        @(negedge clk);
        b_valid = 1'b1;
        b_data  = 8'h00;
        n = 0;
        while (acc_b < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ones = 0;
        for (int i = 0; i < 22; i++) begin
            if (b_tx) ones++;
            @(negedge clk);
        end
        n = 0;
        while (acc_b < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        b_valid = 1'b0;
        chk("s2_accepts", acc_b, 2);
        chk("s2_spacing", b_last - b_prev, 22);
        chk("s2_stop_high", ones, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
